// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer with wrap-bit pointers, multi-port CDB writeback,
// store-retire handshake and single-cycle branch/jalr flush. Optional macro: ROB_CDB_FORWARD_EN.
module reorder_buffer #(
    parameter  int DEPTH   = 8,
    parameter  int NUM_CDB = 2,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [6:0]               enq_opcode,
    input  logic [4:0]               enq_rd,
    output logic [TAG_W-1:0]         enq_tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*32-1:0]    cdb_value,
    input  logic [NUM_CDB*32-1:0]    cdb_target_pc,
    input  logic [NUM_CDB-1:0]       cdb_redirect,
    output logic                     commit_valid,
    output logic [TAG_W-1:0]         commit_tag,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_value,
    output logic                     store_commit_req,
    input  logic                     store_done,
    output logic [TAG_W-1:0]         head_tag,
    output logic                     flush,
    output logic [31:0]              redirect_pc,
    output logic [TAG_W:0]           count,
    output logic                     empty,
    output logic                     full
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT,
        ST_DONE
    } entry_state_t;

    localparam logic [6:0]   OP_BR    = 7'b1100011;
    localparam logic [6:0]   OP_JALR  = 7'b1100111;
    localparam logic [6:0]   OP_STORE = 7'b0100011;
    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    entry_state_t      state_q  [DEPTH];
    logic [6:0]        opcode_q [DEPTH];
    logic [4:0]        rd_q     [DEPTH];
    logic [31:0]       value_q  [DEPTH];
    logic [31:0]       target_q [DEPTH];
    logic [DEPTH-1:0]  redir_q;

    logic [TAG_W:0]    head_q;
    logic [TAG_W:0]    tail_q;
    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    logic              enq_fire;

    logic              head_is_store;
    logic              head_is_br;
    logic              head_is_jalr;
    logic              head_is_plain;

    logic              fwd_hit;
    logic [31:0]       fwd_value;

    logic              retire_fire;
    logic              commit_fire;
    logic [31:0]       commit_data;
    logic              flush_fire;
    logic [31:0]       flush_target;

    assign head_idx  = head_q[TAG_W-1:0];
    assign tail_idx  = tail_q[TAG_W-1:0];
    assign full      = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign empty     = (head_q == tail_q);
    assign count     = tail_q - head_q;
    assign enq_ready = !full && !flush && !rst;
    assign enq_fire  = enq_valid && enq_ready;
    assign enq_tag   = tail_idx;
    assign head_tag  = head_idx;

    always_comb begin
        head_is_store = (opcode_q[head_idx] == OP_STORE);
        head_is_br    = (opcode_q[head_idx] == OP_BR);
        head_is_jalr  = (opcode_q[head_idx] == OP_JALR);
        head_is_plain = !(head_is_store || head_is_br || head_is_jalr);
    end

    assign store_commit_req = (state_q[head_idx] == ST_DONE) && head_is_store;

`ifdef ROB_CDB_FORWARD_EN
    // Descending scan so the lowest-numbered matching port is the one kept.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_value = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == head_idx)) begin
                fwd_hit   = 1'b1;
                fwd_value = cdb_value[p*32 +: 32];
            end
        end
    end
`else
    assign fwd_hit   = 1'b0;
    assign fwd_value = '0;
`endif

    always_comb begin
        retire_fire  = 1'b0;
        commit_fire  = 1'b0;
        commit_data  = '0;
        flush_fire   = 1'b0;
        flush_target = '0;
        if (state_q[head_idx] == ST_DONE) begin
            if (head_is_store) begin
                retire_fire = store_done;
            end else if (head_is_br) begin
                retire_fire  = 1'b1;
                flush_fire   = redir_q[head_idx];
                flush_target = target_q[head_idx];
            end else if (head_is_jalr) begin
                retire_fire  = 1'b1;
                commit_fire  = 1'b1;
                commit_data  = value_q[head_idx];
                flush_fire   = 1'b1;
                flush_target = target_q[head_idx];
            end else begin
                retire_fire = 1'b1;
                commit_fire = 1'b1;
                commit_data = value_q[head_idx];
            end
        end else if ((state_q[head_idx] == ST_WAIT) && fwd_hit && head_is_plain) begin
            retire_fire = 1'b1;
            commit_fire = 1'b1;
            commit_data = fwd_value;
        end
    end

    // Later assignments win: retire overrides a CDB write to the forwarded head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_EMPTY;
            end
            head_q       <= '0;
            tail_q       <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            flush        <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            commit_valid <= commit_fire;
            commit_tag   <= commit_fire ? head_idx : '0;
            commit_rd    <= commit_fire ? rd_q[head_idx] : '0;
            commit_value <= commit_data;
            flush        <= flush_fire;
            redirect_pc  <= flush_fire ? flush_target : '0;
            if (flush_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    state_q[i] <= ST_EMPTY;
                end
                head_q <= '0;
                tail_q <= '0;
            end else begin
                for (int p = NUM_CDB - 1; p >= 0; p--) begin
                    if (cdb_valid[p] && (state_q[cdb_tag[p*TAG_W +: TAG_W]] == ST_WAIT)) begin
                        state_q[cdb_tag[p*TAG_W +: TAG_W]]  <= ST_DONE;
                        value_q[cdb_tag[p*TAG_W +: TAG_W]]  <= cdb_value[p*32 +: 32];
                        target_q[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_target_pc[p*32 +: 32];
                        redir_q[cdb_tag[p*TAG_W +: TAG_W]]  <= cdb_redirect[p];
                    end
                end
                if (retire_fire) begin
                    state_q[head_idx] <= ST_EMPTY;
                    head_q            <= head_q + PTR_ONE;
                end
                if (enq_fire) begin
                    state_q[tail_idx]  <= ST_WAIT;
                    opcode_q[tail_idx] <= enq_opcode;
                    rd_q[tail_idx]     <= enq_rd;
                    value_q[tail_idx]  <= '0;
                    tail_q             <= tail_q + PTR_ONE;
                end
            end
        end
    end

endmodule
